spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_resp_sync.sv | 45 ++++
 rtl/spi_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state encoding for the SPI register
// responder (spi_responder, spi_resp_sync).
//   DATA_W_DEF     data field width
//   ADDR_W_DEF     address field width
//   FRAME_BITS_DEF bits per frame: address, R/W bit, data
//   state_t        responder FSM states
package spi_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 9;
  localparam int FRAME_BITS_DEF = ADDR_W_DEF + 1 + DATA_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    WAIT_SS
  } state_t;

endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: 2-flop synchronizers for the asynchronous SPI pins and
// edge detection on the synchronized sck and ss_n.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ss_n, sck, mosi   raw SPI pins from the initiator
//   mosi_s            synchronized mosi, aligned with the sck edge flags
//   sck_rise/sck_fall one-clk pulses on synchronized sck edges
//   ss_rise/ss_fall   one-clk pulses on synchronized ss_n edges
module spi_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic sck,
  input  logic mosi,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall
);

  // [0] first flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] ss_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n};
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign mosi_s   = mosi_q[1];
  assign sck_rise =  sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] &  sck_q[2];
  assign ss_rise  =  ss_q[1]  & ~ss_q[2];
  assign ss_fall  = ~ss_q[1]  &  ss_q[2];

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target that turns each frame
// {addr, R/W (1 = write), data}, MSB first, into a register-file write
// strobe or read request. clk must run at least 8x sck.
// Optional build macro: SPI_RESP_FRAME_ERR_EN enables the frame_err abort
// pulse; without it frame_err is tied 0 (aborts still return to IDLE).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ss_n, sck, mosi   SPI pins from the initiator (asynchronous)
//   miso, miso_oe     serial read data and its tri-state enable
//   reg_addr          address of the last frame
//   reg_wdata         last written data
//   reg_we, reg_rd    one-clk write strobe / read request
//   reg_rdata         read data, valid one clk after reg_rd
//   frame_err         one-clk pulse when a frame is cut short by ss_n
//
// state   | meaning
// IDLE    | waiting for ss_n to fall
// HDR     | shifting in address and R/W bit
// WDATA   | shifting in write data
// RDATA   | shifting out read data on miso
// WAIT_SS | frame complete, ignoring sck until ss_n rises
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FRAME_BITS = ADDR_W + 1 + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  // Receive shifter only needs to hold the address, or all but the last
  // data bit (the last one is taken straight from mosi).
  localparam int SH_W  = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam logic [CNT_W-1:0] CNT_RW   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic mosi_s, sck_rise, sck_fall, ss_rise, ss_fall;

  spi_resp_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .sck      (sck),
    .mosi     (mosi),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              rd_d;
  logic              start, bit_rise, hdr_done, frame_done, tx_fall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ss_n rising wins over any sck edge seen in the same clk.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    bit_rise   = 1'b0;
    hdr_done   = 1'b0;
    frame_done = 1'b0;
    tx_fall    = 1'b0;
    if (ss_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            start     = 1'b1;
            state_nxt = HDR;
          end
        end
        HDR: begin
          bit_rise = sck_rise;
          if (sck_rise && cnt == CNT_RW) begin
            hdr_done  = 1'b1;
            state_nxt = mosi_s ? WDATA : RDATA;
          end
        end
        WDATA, RDATA: begin
          bit_rise = sck_rise;
          tx_fall  = sck_fall && (state == RDATA);
          if (sck_rise && cnt == CNT_LAST) begin
            frame_done = 1'b1;
            state_nxt  = WAIT_SS;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rd_d      <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_rd <= 1'b0;
      rd_d   <= reg_rd;
      if (start) cnt <= '0;
      if (bit_rise) begin
        cnt   <= cnt + CNT_W'(1);
        rx_sh <= {rx_sh[SH_W-2:0], mosi_s};
      end
      if (hdr_done) begin
        reg_addr <= rx_sh[ADDR_W-1:0];
        if (!mosi_s) begin
          reg_rd  <= 1'b1;
          miso_oe <= 1'b1;
        end
      end
      // Register file answers one clk after reg_rd.
      if (rd_d && state == RDATA) tx_sh <= reg_rdata;
      if (tx_fall) begin
        miso  <= tx_sh[DATA_W-1];
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end
      if (frame_done) begin
        miso <= 1'b0;
        if (state == WDATA) begin
          reg_wdata <= {rx_sh[DATA_W-2:0], mosi_s};
          reg_we    <= 1'b1;
        end
      end
      if (ss_rise) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
    end
  end

`ifdef SPI_RESP_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= ss_rise && (state == HDR || state == WDATA || state == RDATA);
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
